// File: rtl/corescore_stream_pkg.sv
// Shared constants and the stored entry format for the CoreScore byte stream FIFO.
package corescore_stream_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/corescore_fifo_mem.sv
// Simple dual-port entry storage: synchronous write, asynchronous read (distributed RAM style).
module corescore_fifo_mem
  import corescore_stream_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  // Contents are deliberately left unreset; validity is tracked by the pointers.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/corescore_stream_fifo.sv
// Byte stream FIFO between the CoreScore producer and the UART emitter, with optional
// store-and-forward on tlast-delimited packets (PKT_MODE=1) or cut-through (PKT_MODE=0).
module corescore_stream_fifo
  import corescore_stream_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int PKT_MODE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [BYTE_W-1:0]        i_tdata,
  input  logic                     i_tlast,
  input  logic                     i_tvalid,
  output logic                     o_tready,
  output logic [BYTE_W-1:0]        o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            PW       = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      level_q, level_d;
  logic [PW-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic               flush_q, flush_d;
  logic               rdy_q, rdy_d;
  logic               wr_en, rd_en, vld;
  logic               wr_last, rd_last;
  logic [ENTRY_W-1:0] rd_bits;
  entry_t             head;

  corescore_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata ({i_tlast, i_tdata}),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (rd_bits)
  );

  assign head = entry_t'(rd_bits);

  // In packet mode the head is held back until a complete packet is stored, unless the
  // packet outgrew the buffer, in which case flush lets it stream out cut-through.
  always_comb begin
    if (PKT_MODE != 0) begin
      vld = (level_q != '0) && ((pkt_cnt_q != '0) || flush_q);
    end else begin
      vld = (level_q != '0);
    end
    wr_en   = i_tvalid && rdy_q;
    rd_en   = vld && i_tready;
    wr_last = wr_en && i_tlast;
    rd_last = rd_en && head.last;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    flush_d   = flush_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    if (rd_last) flush_d = 1'b0;
    if ((level_d == FULL_LVL) && (pkt_cnt_d == '0)) flush_d = 1'b1;

    // Ready is registered so it stays low through reset and has no path from i_tready.
    rdy_d = (level_d != FULL_LVL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      flush_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      flush_q   <= flush_d;
      rdy_q     <= rdy_d;
    end
  end

  assign o_tready = rdy_q;
  assign o_tvalid = vld;
  assign o_tdata  = vld ? head.data : '0;
  assign o_tlast  = vld && head.last;
  assign o_level  = level_q;

endmodule

// File: doc/corescore_stream_fifo.md
CORESCORE_STREAM_FIFO -- requirements
Module: corescore_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of byte entries; it must be a power of two and at least 4.
REQ-002 SHALL have parameter PKT_MODE, default 1: 1 = store-and-forward per tlast-delimited packet, 0 = cut-through.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port i_tdata, input, 8 bits: upstream byte.
REQ-006 SHALL have port i_tlast, input, 1 bit: marks the last byte of a packet.
REQ-007 SHALL have port i_tvalid, input, 1 bit: upstream byte valid.
REQ-008 SHALL have port o_tready, output, 1 bit: the FIFO accepts a byte.
REQ-009 SHALL have port o_tdata, output, 8 bits: byte to the UART emitter.
REQ-010 SHALL have port o_tlast, output, 1 bit: last-byte flag of the head entry.
REQ-011 SHALL have port o_tvalid, output, 1 bit: head entry is presentable.
REQ-012 SHALL have port i_tready, input, 1 bit: downstream accepts.
REQ-013 SHALL have port o_level, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 SHALL store {tlast, tdata}, 9 bits per entry, in a circular buffer with read/write pointers of clog2(DEPTH)+1 bits; wrap-around SHALL be by natural pointer overflow.
REQ-015 SHALL drive o_tready = (level != DEPTH), derived from registered state only, with no combinational path from i_tready.
REQ-016 SHALL write on i_tvalid && o_tready; when full, a same-cycle read SHALL NOT enable a write.
REQ-017 SHALL read on o_tvalid && i_tready; o_tdata/o_tlast SHALL be the head entry and SHALL hold stable while o_tvalid && !i_tready.
REQ-018 SHALL update level as +1 on write only, -1 on read only, and leave it unchanged on simultaneous write and read.
REQ-019 In PKT_MODE=0, o_tvalid SHALL equal (level != 0); a byte written at edge N SHALL be visible at o_tvalid after edge N, i.e. 1-cycle latency.
REQ-020 In PKT_MODE=1, SHALL keep pkt_cnt, the number of stored tlast entries (width clog2(DEPTH)+1): +1 on a write with i_tlast, -1 on a read with o_tlast, unchanged when both occur.
REQ-021 In PKT_MODE=1, the flush flag SHALL be set when level == DEPTH and pkt_cnt == 0 (oversize packet), and cleared on a read with o_tlast.
REQ-022 In PKT_MODE=1, o_tvalid SHALL equal (level != 0) && (pkt_cnt != 0 || flush); once asserted it SHALL NOT deassert before a handshake.
REQ-023 In PKT_MODE=1, the first byte of a packet SHALL appear no earlier than the cycle after its tlast byte is written.
REQ-024 i_tvalid with o_tready low SHALL cause no state change, and no data SHALL be lost or duplicated.

Reset
REQ-025 While i_rst_n is low, SHALL clear pointers, level, pkt_cnt and flush, and drive o_tvalid=0, o_tready=0, o_tdata=0, o_tlast=0 and o_level=0.
REQ-026 o_tready SHALL rise on the first clock edge after i_rst_n deasserts.
REQ-027 An assertion of reset mid-packet SHALL discard all stored data, with no partial packet emitted afterwards.
REQ-028 Deassertion of reset SHALL be synchronous to i_clk, handled externally.
REQ-029 Storage contents need no reset.

Structure
REQ-030 Package corescore_stream_pkg SHALL hold the byte width constant (8), the default DEPTH and the 9-bit entry typedef.
REQ-031 Storage SHALL be a sub-module corescore_fifo_mem: simple dual-port, synchronous write, asynchronous read, inferable as distributed RAM.
REQ-032 Pointer, count and packet logic SHALL reside in corescore_stream_fifo.

Verification
REQ-033 Cut-through test: PKT_MODE=0, write 0x41 with i_tready=1 -> o_tvalid=1 and o_tdata=0x41 in the next cycle, and o_level returns to 0 after the read.
REQ-034 Store-and-forward test: PKT_MODE=1, write 0x10, 0x11, 0x12 (tlast) -> o_tvalid stays 0 until the cycle after 0x12 is written, then the three bytes are emitted in order with o_tlast only on 0x12.
REQ-035 Full test: DEPTH=16 with i_tready=0, write 20 bytes -> o_tready=0 after the 16th byte, o_level=16, and bytes 1-16 drain intact.
REQ-036 Oversize-packet test: PKT_MODE=1, 16 bytes without tlast -> flush is set, o_tvalid=1, bytes drain; a 17th byte with tlast is accepted, then flush clears on its read.
REQ-037 Simultaneous read/write test: at level 5 with continuous write and read for 100 cycles -> level remains 5, and data order is preserved across pointer wrap.
REQ-038 Reset test: pulse i_rst_n low mid-packet -> o_tvalid=0 and o_level=0 immediately, and the next packet emerges with no stale bytes.
